serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor computing `a - b - bin` one bit per clock, LSB first, using a single registered borrow.
- It is the inverse-operation counterpart of the combinational parallel adder: it trades area for latency and is used in datapaths that have spare cycles.
- It provides a start/busy/done handshake and registered flag outputs (borrow-out, signed overflow, zero).

Parameters:
- `WIDTH`, 8, operand and result width in bits. Legal range is WIDTH >= 2.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request a new operation; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge only.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge only.
- `bin`  input  1  borrow-in; sampled on the accepting edge only.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when the results update.
- `diff`  output  WIDTH  result `a - b - bin`, modulo 2^WIDTH.
- `bout`  output  1  borrow-out, i.e. unsigned `a < b + bin`.
- `ovf`  output  1  two's-complement signed overflow of the subtraction.
- `zero`  output  1  high when `diff == 0`.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, any state): state goes to IDLE. `busy`, `done`, `diff`, `bout`, `ovf` and `zero` all go to 0, as do all internal shift registers, the bit counter and the borrow register.
- Reset mid-operation aborts the operation. No `done` is produced and the results read 0.
- FSM states are IDLE and RUN.
- IDLE:
  - `start = 1` on edge T0 loads shift registers A <= a, B <= b, borrow register br <= bin, counter <= 0.
  - The same edge sets `busy` <= 1 and moves to RUN.
  - `start = 0` holds IDLE.
- RUN, each edge:
  - Take x = A[0], y = B[0].
  - Result bit d = x ^ y ^ br.
  - Next borrow br <= (~x & y) | (~(x ^ y) & br).
  - d is shifted into the MSB of the internal result register; A and B shift right by one.
  - The counter increments.
- Completion edge (counter == WIDTH-1 processing the final bit), reached at edge T_WIDTH:
  - `diff` <= completed result.
  - `bout` <= final borrow.
  - `zero` <= (completed result == 0).
  - `ovf` <= (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the latched operand MSBs.
  - `done` <= 1, `busy` <= 0, state returns to IDLE.
- Latency: `done` is high exactly WIDTH cycles after the edge that accepted `start`. Throughput is one operation per WIDTH cycles.
- `done` is high for exactly one cycle and is cleared on the next edge.
- `diff`, `bout`, `ovf` and `zero` hold their last completed values until the next completion edge. They never show partial results while `busy` is high.
- `start` while `busy = 1` is ignored: no restart, no queueing. Inputs `a`, `b` and `bin` may change freely during RUN.
- `start` in the cycle where `done = 1` (state is IDLE) is accepted. This gives back-to-back operations with no idle gap: `busy` goes high again on that edge and `done` falls.
- `bin` applies to bit 0 only. Arithmetic is identical to a WIDTH-bit two's-complement subtract with borrow chain.
- Bit counter is sized $clog2(WIDTH) bits (at least 1). There is no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulsed -> `busy` high for 8 cycles; `done` pulses 8 cycles after acceptance; `diff`=0x02, `bout`=0, `ovf`=0, `zero`=0.
- a=0x03, b=0x05, bin=0 -> `diff`=0xFE, `bout`=1, `ovf`=0. Then a=0x00, b=0x00, bin=1 -> `diff`=0xFF, `bout`=1, `zero`=0.
- a=0x80, b=0x01, bin=0 -> `diff`=0x7F, `ovf`=1, `bout`=0. Then a=0x7F, b=0xFF -> `diff`=0x80, `ovf`=1, `bout`=1.
- a=0x2A, b=0x2A, bin=0 -> `diff`=0x00, `zero`=1. Then a=0x2A, b=0x29, bin=1 -> `diff`=0x00, `zero`=1, `bout`=0.
- Hold `start`=1 with new operands during RUN -> ignored, first result unchanged. Assert `start` in the `done` cycle with a=0x10, b=0x01 -> second `done` exactly 8 cycles later with `diff`=0x0F. Previous results are stable in between.
- Drive `rst_n`=0 for one cycle at bit 4 of an operation -> all outputs 0 immediately and no `done`. A subsequent start of a=0x09, b=0x04 yields `diff`=0x05 with normal latency.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave returns busy/done and the registered flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock with a single registered borrow.
// Results and flags are registered and only change on the completion edge.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor slice applied to the current LSBs.
    always_comb begin
        x        = a_sr[0];
        y        = b_sr[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        res_next = {d, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        br       <= bus.bin;
                        res_sr   <= '0;
                        cnt      <= '0;
                        a_msb    <= bus.a[WIDTH-1];
                        b_msb    <= bus.b[WIDTH-1];
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    // Final bit: publish everything at once; d is the result MSB here.
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt      <= '0;
                        bus.diff <= res_next;
                        bus.bout <= br_next;
                        bus.zero <= (res_next == '0);
                        bus.ovf  <= (a_msb ^ b_msb) & (a_msb ^ d);
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, back-to-back, reset abort and random ops
// checked against a plain-arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the unsigned and signed readings of the operands.
    task automatic modelSub(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                            output logic [W-1:0] ediff, output logic ebout,
                            output logic eovf, output logic ezero);
        int ua, ub, sa, sb, ur, sr;
        ua    = int'(ma);
        ub    = int'(mb);
        sa    = $signed(ma);
        sb    = $signed(mb);
        ur    = ua - ub - int'(mbin);
        sr    = sa - sb - int'(mbin);
        ediff = W'(ur);
        ebout = (ua < ub + int'(mbin));
        eovf  = (sr < -(2 ** (W - 1))) || (sr > (2 ** (W - 1)) - 1);
        ezero = (ediff == '0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one operation at the current (post-edge) time and follow it through completion.
    // Returns just after the done edge, so a following call starts in the done cycle.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                                 input logic tbin, input bit hold_start);
        logic [W-1:0] ediff;
        logic         ebout, eovf, ezero;
        logic [W-1:0] prev_diff;
        logic         prev_bout, prev_ovf, prev_zero;
        int           k;
        bit           stable;

        modelSub(ta, tb_op, tbin, ediff, ebout, eovf, ezero);
        prev_diff = bus.diff;
        prev_bout = bus.bout;
        prev_ovf  = bus.ovf;
        prev_zero = bus.zero;

        bus.a     = ta;
        bus.b     = tb_op;
        bus.bin   = tbin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_on_accept", 32'(bus.busy), 32'd1);
        checkOutput("done_on_accept", 32'(bus.done), 32'd0);

        k      = 0;
        stable = 1'b1;
        while (!bus.done && k < W + 4) begin
            bus.start = hold_start;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
            if (bus.diff !== prev_diff || bus.bout !== prev_bout ||
                bus.ovf !== prev_ovf || bus.zero !== prev_zero || bus.busy !== 1'b1)
                stable = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;

        checkOutput("latency", 32'(k), 32'(W));
        checkOutput("stable_while_busy", 32'(stable), 32'd1);
        checkOutput("done", 32'(bus.done), 32'd1);
        checkOutput("busy_after", 32'(bus.busy), 32'd0);
        checkOutput("diff", 32'(bus.diff), 32'(ediff));
        checkOutput("bout", 32'(bus.bout), 32'(ebout));
        checkOutput("ovf", 32'(bus.ovf), 32'(eovf));
        checkOutput("zero", 32'(bus.zero), 32'(ezero));
    endtask

    task automatic finishOp();
        idleCycles(1);
        checkOutput("done_cleared", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        compared   = 0;
        mismatched = 0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.bin    = 1'b0;
        rst_n      = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_diff", 32'(bus.diff), 32'd0);
        checkOutput("rst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed cases");
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b0); finishOp();
        applyStimulus(8'h03, 8'h05, 1'b0, 1'b0); finishOp();
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0); finishOp();
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0); finishOp();
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b0); finishOp();
        applyStimulus(8'h2A, 8'h2A, 1'b0, 1'b0); finishOp();
        applyStimulus(8'h2A, 8'h29, 1'b1, 1'b0); finishOp();
        applyStimulus(8'h80, 8'h00, 1'b1, 1'b0); finishOp();

        $display("[TB] start held during run, then back-to-back");
        applyStimulus(8'h55, 8'h11, 1'b0, 1'b1);
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b0);
        finishOp();

        $display("[TB] reset mid-operation");
        bus.a     = 8'h77;
        bus.b     = 8'h22;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        idleCycles(4);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_diff", 32'(bus.diff), 32'd0);
        checkOutput("abort_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        checkOutput("no_done_after_abort", 32'(dones), 32'd0);
        applyStimulus(8'h09, 8'h04, 1'b0, 1'b0);
        finishOp();

        $display("[TB] random operations");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) finishOp();
        end
        finishOp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
